// File: rtl/sha256_msg_schedule_pkg.sv
// rtl/sha256_msg_schedule_pkg.sv - SHA-256 round constants, sigma functions and schedule FSM encoding
package sha256_msg_schedule_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int WORDS     = 16;
    localparam int LAST_ROUND = 63;

    localparam logic [0:63][31:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotations written as concatenations so each is pure wiring.
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block load and schedule word handshake bundle
interface sha256_msg_schedule_if;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_ready;
    logic [31:0]  word;
    logic [31:0]  const_k;
    logic [5:0]   round;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;

    modport master (
        output blk_valid, blk_data, word_ready,
        input  blk_ready, word, const_k, round, word_valid, word_last
    );

    modport slave (
        input  blk_valid, blk_data, word_ready,
        output blk_ready, word, const_k, round, word_valid, word_last
    );
endinterface

// File: rtl/sha256_k_rom.sv
// rtl/sha256_k_rom.sv - combinational SHA-256 round constant lookup
module sha256_k_rom
    import sha256_msg_schedule_pkg::*;
(
    input  logic [5:0]  addr,
    output logic [31:0] k
);
    assign k = K_TABLE[addr];
endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule, one W[t]/K[t] pair per handshake
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
(
    input  logic                     clkm,
    input  logic                     rst,
    sha256_msg_schedule_if.slave     bus
);
    state_t      state_q, state_d;
    logic [5:0]  t_q;
    logic [31:0] w_q [WORDS];
    logic [31:0] w_next;
    logic        load, adv, fin;

    always_ff @(posedge clkm) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.blk_ready  = 1'b0;
        bus.word_valid = 1'b0;
        load           = 1'b0;
        adv            = 1'b0;
        fin            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.blk_ready = 1'b1;
                if (bus.blk_valid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.word_valid = 1'b1;
                if (bus.word_ready) begin
                    if (t_q == 6'(LAST_ROUND)) begin
                        fin     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next window entry is W[t+16], computed from the live 16-word window.
    assign w_next = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_ff @(posedge clkm) begin
        if (rst) begin
            t_q <= 6'd0;
            for (int i = 0; i < WORDS; i++) w_q[i] <= 32'd0;
        end else if (load) begin
            t_q <= 6'd0;
            for (int i = 0; i < WORDS; i++) w_q[i] <= bus.blk_data[(15 - i) * 32 +: 32];
        end else if (adv) begin
            t_q <= t_q + 6'd1;
            for (int i = 0; i < WORDS - 1; i++) w_q[i] <= w_q[i + 1];
            w_q[WORDS - 1] <= w_next;
        end else if (fin) begin
            t_q <= 6'd0;
        end
    end

    assign bus.word      = w_q[0];
    assign bus.round     = t_q;
    assign bus.word_last = (state_q == ST_RUN) && (t_q == 6'(LAST_ROUND));

    sha256_k_rom u_k_rom (
        .addr (t_q),
        .k    (bus.const_k)
    );
endmodule

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 SHALL have ports: clkm  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have: blk_valid  in  1  a 512-bit block is offered on blk_data.
REQ-004 SHALL have: blk_data  in  512  padded message block, big-endian, W[0]=blk_data[511:480].
REQ-005 SHALL have: blk_ready  out  1  block is accepted this cycle if blk_valid is also high.
REQ-006 SHALL have: word  out  32  schedule word W[t], consumed by the T1 adder as its word input.
REQ-007 SHALL have: const_k  out  32  round constant K[t], consumed by the T1 adder as its const input.
REQ-008 SHALL have: round  out  6  current t.
REQ-009 SHALL have: word_valid  out  1  word, const_k and round are valid.
REQ-010 SHALL have: word_ready  in  1  consumer accepts the current word.
REQ-011 SHALL have: word_last  out  1  high with word_valid when t=63.

Function
REQ-012 SHALL implement two states: IDLE and RUN.
REQ-013 IDLE: blk_ready=1, word_valid=0; blk_valid=1 loads blk_data into a 16x32 window w[0..15], sets t=0 and moves to RUN next cycle.
REQ-014 RUN: blk_ready=0, word_valid=1, word=w[0], const_k=K[t], round=t, word_last=(t==63).
REQ-015 Handshake occurs when word_valid and word_ready are both high; only a handshake advances t or the window.
REQ-016 On a handshake in RUN with t<63, the window SHALL shift down one slot (w[i]<=w[i+1]); w[15] takes sigma1(w[14])+w[9]+sigma0(w[1])+w[0], mod 2^32; t<=t+1.
REQ-017 sigma0(x)=ROTR7(x)^ROTR18(x)^SHR3(x); sigma1(x)=ROTR17(x)^ROTR19(x)^SHR10(x); additions wrap at 32 bits, carries discarded.
REQ-018 On a handshake at t=63 the block SHALL return to IDLE; blk_ready=1 on the following cycle; no new word is issued until a new load.
REQ-019 With word_ready low, word, const_k, round and word_last SHALL hold stable for any number of cycles.
REQ-020 blk_valid while in RUN SHALL be ignored; the block in flight is not disturbed.
REQ-021 Output latency: first word_valid exactly one cycle after the load handshake; 64 words need at least 64 RUN cycles (65 cycles load-to-IDLE with word_ready held high).
REQ-022 Words 16..63 SHALL be produced on the fly without stall cycles; throughput is one word per cycle.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, t=0 and the window to all zero, whatever the current state.
REQ-024 Output values after reset: blk_ready=1, word_valid=0, word_last=0, round=0, word=0, const_k=K[0] (0x428a2f98).
REQ-025 Reset during RUN SHALL abandon the block; no further words from it appear.

Structure
REQ-026 A shared package SHALL hold the 64-entry K constant table, the sigma0/sigma1 functions and the state encoding.
REQ-027 The K lookup SHALL be one sub-module, sha256_k_rom (6-bit address in, 32-bit constant out, combinational), reusable by other round logic.

Verification
REQ-028 Test block for "abc" (0x61626380, then zeros, with final word 0x00000018), word_ready held high: the bench SHALL check W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, K63=0xC67178F2, and word_last only at t=63.
REQ-029 All-zero block: every W[0..63]=0; blk_ready returns high 65 cycles after load.
REQ-030 "abc" block with word_ready low for 3 cycles at t=5: outputs hold at t=5 for those cycles, then the sequence resumes with an unchanged W[6..63] sequence.
REQ-031 rst pulsed at t=20: next cycle word_valid=0, blk_ready=1, round=0; a fresh "abc" load then reproduces REQ-028.
REQ-032 blk_valid pulsed with a different block at t=10: it is ignored; the sequence still matches "abc"; no load until IDLE.
REQ-033 Back-to-back: blk_valid held high with two blocks; the second load is accepted on the first IDLE cycle after t=63.
